sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM (1024 x 16, 1-cycle registered read) among NREQ requesters, e.g. weight loader, activation loader and result writeback.
- Uses round-robin arbitration with valid/ready handshakes.
- Supports locked bursts terminated by req_last or a MAX_BURST cap.
- Returns read data to the issuing requester one cycle after the accepted beat.
- Sits between the SRAM instance and the FIFO-fed load/store engines.

Parameters:
- NREQ, 3, number of requesters (2..8).
- WIDTH, 16, data width.
- DEPTH, 1024, SRAM words.
- AW, $clog2(DEPTH), address width (derived, not overridden).
- MAX_BURST, 16, maximum beats per grant before forced release (power of 2, >=1).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester beat valid.
- req_ready  out  NREQ  per-requester beat accepted.
- req_we  in  NREQ  1 = write beat, 0 = read beat.
- req_last  in  NREQ  final beat of the requester's burst.
- req_addr  in  NREQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_wdata  in  NREQ*WIDTH  packed write data.
- rsp_valid  out  NREQ  one-hot read-data-valid to the issuing requester.
- rsp_rdata  out  WIDTH  read data, shared by all requesters.
- mem_en  out  1  SRAM access enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  AW  SRAM address.
- mem_wdata  out  WIDTH  SRAM write data.
- mem_rdata  in  WIDTH  SRAM read data, valid the cycle after a read access.
- busy  out  1  burst in progress or read response pending.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - State IDLE, last_owner = NREQ-1 (req 0 has first priority), beat_cnt = 0.
  - rsp_valid = 0, rsp_rdata = 0, busy = 0.
  - While rst is high, req_ready = 0 and mem_en = 0 regardless of inputs.
- Handshake:
  - A beat transfers when req_valid[i] & req_ready[i].
  - req_ready is combinational from req_valid and state.
  - At most one req_ready bit is high per cycle.
  - Requester inputs must stay stable while valid && !ready.
- IDLE:
  - Winner w is the first requester with req_valid set, scanning from last_owner+1 and wrapping modulo NREQ. req_ready[w] = 1 in the same cycle.
  - If none are valid, all req_ready = 0.
  - On the transfer, if req_last[w] or MAX_BURST == 1: stay IDLE, last_owner <= w.
  - Otherwise: go to BURST, owner <= w, beat_cnt <= 1.
- BURST:
  - req_ready[owner] = req_valid[owner]; all other ready bits are 0.
  - If owner drops valid, the grant is held and no SRAM access occurs (bubble).
  - On transfer: beat_cnt++.
  - If req_last[owner], or beat_cnt+1 == MAX_BURST: go to IDLE, last_owner <= owner, beat_cnt <= 0.
  - A forced release does not notify the requester; its next beat re-arbitrates.
- SRAM drive (combinational from the selected requester):
  - mem_en = transfer, mem_we = req_we[sel], mem_addr = req_addr[sel], mem_wdata = req_wdata[sel].
  - mem_addr/mem_wdata are don't-care when mem_en = 0, but driven from sel (no X).
- Read return:
  - A read transfer at cycle t from requester i gives rsp_valid[i] = 1 at t+1 for exactly one cycle, with rsp_rdata = mem_rdata.
  - Reads are back-to-back capable: one response per cycle, in order.
  - Writes produce no response.
  - Write-then-read to the same address on consecutive cycles returns the new data (SRAM ordering).
- busy = (state == BURST) | (|rsp_valid pending register).
- Reset mid-burst:
  - Returns to IDLE next edge.
  - A pending response is dropped (rsp_valid = 0).
  - last_owner resets to NREQ-1.
- Fairness: with all requesters continuously valid and single-beat, grants rotate 0,1,2,0,...; no requester waits more than (NREQ-1)*MAX_BURST accepted beats.

Decomposition:
- Shared include/package tpu_mem_pkg holds:
  - State encoding localparams ST_IDLE = 1'b0, ST_BURST = 1'b1.
  - Default SRAM geometry constants SRAM_WIDTH = 16, SRAM_DEPTH = 1024.
- One sub-module: rr_arbiter (NREQ), which holds no state of its own. It has:
  - Inputs: req vector and last_owner.
  - Outputs: one-hot grant and encoded index.
- Pointer update, burst FSM, beat counter and response pipeline stay in sram_port_arbiter.

Test Plan:
- Reset, then req0 single-beat write addr 5 data 16'hBEEF, then req0 read addr 5 -> req_ready[0] = 1 both cycles, mem_we = 1 then 0, rsp_valid = 3'b001 one cycle after the read, rsp_rdata = 16'hBEEF.
- All three requesters valid with single-beat reads to addrs 1/2/3 for 6 cycles -> grant order 0,1,2,0,1,2; rsp_valid one-hot follows one cycle later in the same order.
- req1 4-beat write burst (last on beat 4) while req0 and req2 are valid -> req_ready stays 3'b010 for 4 transfers, then req2 is granted next (last_owner = 1).
- req0 burst with no req_last and MAX_BURST = 16 -> forced release after 16 transfers, busy drops; next grant goes to req1 if valid, else back to req0.
- req2 in BURST drops valid for 3 cycles while req0 is valid -> req_ready[0] stays 0, mem_en = 0 for 3 cycles, and req2 resumes on re-assert.
- rst asserted for 1 cycle mid-burst with a read response pending -> next cycle state IDLE, rsp_valid = 0, busy = 0; first post-reset grant goes to req0 when all are valid.

Source files
------------

// File: rtl/tpu_mem_pkg.sv
// Shared constants for the TPU memory-side blocks.
//   ST_IDLE / ST_BURST : arbiter FSM state encoding
//   SRAM_WIDTH / SRAM_DEPTH : default SRAM geometry
//   idx_w() : width of an index into n items (at least 1 bit)
package tpu_mem_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  localparam int SRAM_WIDTH = 16;
  localparam int SRAM_DEPTH = 1024;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_BURST = ST_BURST
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side handshake bus plus SRAM-side bus of the port arbiter.
//   req_*  : per-requester beats, packed, requester i at [i*W +: W]
//   rsp_*  : one-hot read return and shared read data
//   mem_*  : single-port SRAM access (read data valid one cycle later)
// slave  : arbiter side; master : requesters + SRAM side.
interface sram_port_arbiter_if
  import tpu_mem_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int WIDTH = SRAM_WIDTH,
  parameter int AW    = $clog2(SRAM_DEPTH)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_we, req_last, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_last, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Stateless round-robin pick.
//   req        : request vector
//   last_owner : index of the previous winner; search starts just after it
//   gnt        : one-hot grant (zero when no request)
//   gnt_idx    : encoded grant index (0 when no request)
module rr_arbiter
  import tpu_mem_pkg::*;
#(
  parameter  int NREQ = 3,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Scan last_owner+1 .. last_owner+NREQ, wrapping, first hit wins.
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_owner) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM among NREQ requesters with round-robin
// arbitration and locked bursts (ended by req_last or MAX_BURST beats).
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester handshake + SRAM bus (slave side)
//   busy     : burst in progress or read response pending
module sram_port_arbiter
  import tpu_mem_pkg::*;
#(
  parameter  int NREQ      = 3,
  parameter  int WIDTH     = SRAM_WIDTH,
  parameter  int DEPTH     = SRAM_DEPTH,
  parameter  int MAX_BURST = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  sram_port_arbiter_if.slave bus,
  output logic              busy
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  arb_state_e      state;
  logic [IW-1:0]   owner, last_owner;
  logic [CW-1:0]   beat_cnt, beat_nxt;
  logic [NREQ-1:0] rsp_oh;

  logic [NREQ-1:0] arb_gnt, ready;
  logic [IW-1:0]   arb_idx, sel;
  logic            xfer, sel_we, sel_last;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (bus.req_valid),
    .last_owner (last_owner),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  // During a burst the owner keeps the port even while it idles.
  assign sel = (state == S_BURST) ? owner : arb_idx;

  always_comb begin
    ready = '0;
    if (!rst) begin
      if (state == S_IDLE) ready = arb_gnt;
      else                 ready[owner] = bus.req_valid[owner];
    end
  end

  assign xfer     = |(ready & bus.req_valid);
  assign sel_we   = bus.req_we[sel];
  assign sel_last = bus.req_last[sel];
  assign beat_nxt = beat_cnt + CW'(1);

  assign bus.req_ready = ready;
  assign bus.mem_en    = xfer;
  assign bus.mem_we    = sel_we;
  assign bus.mem_addr  = bus.req_addr[int'(sel)*AW +: AW];
  assign bus.mem_wdata = bus.req_wdata[int'(sel)*WIDTH +: WIDTH];

  // SRAM read data is already registered; just steer it and hold 0 otherwise.
  assign bus.rsp_valid = rsp_oh;
  assign bus.rsp_rdata = (|rsp_oh) ? bus.mem_rdata : '0;
  assign busy          = (state == S_BURST) | (|rsp_oh);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
      beat_cnt   <= '0;
      rsp_oh     <= '0;
    end else begin
      rsp_oh <= (xfer && !sel_we) ? (NREQ'(1) << sel) : '0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            if (sel_last || MAX_BURST == 1) begin
              last_owner <= sel;
            end else begin
              state    <= S_BURST;
              owner    <= sel;
              beat_cnt <= CW'(1);
            end
          end
        end
        S_BURST: begin
          if (xfer) begin
            // Cap release is silent: the requester's next beat re-arbitrates.
            if (sel_last || beat_nxt == CW'(MAX_BURST)) begin
              state      <= S_IDLE;
              last_owner <= owner;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_nxt;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
  import tpu_mem_pkg::*;

  localparam int NREQ  = 3;
  localparam int WIDTH = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int MB    = 16;

  typedef struct {
    int            gap;
    bit            we;
    bit            last;
    bit [AW-1:0]   addr;
    bit [WIDTH-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus ();

  sram_port_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // SRAM behavioural model: 1-cycle registered read.
  logic [WIDTH-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= sram[bus.mem_addr];
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Requester agents: one queue of beats per requester.
  beat_t           q [NREQ][$];
  bit [NREQ-1:0]   cur_v;
  int              gap_cnt [NREQ];
  bit [NREQ-1:0]   acc;

  // Reference model: who owns the port, whose turn is next, pending response.
  bit              m_burst;
  int              m_owner, m_lo, m_cnt;
  bit [NREQ-1:0]   m_rsp;
  bit [WIDTH-1:0]  m_rdata;
  bit [WIDTH-1:0]  ref_mem [DEPTH];

  task automatic model_reset();
    m_burst = 0; m_owner = 0; m_lo = NREQ - 1; m_cnt = 0; m_rsp = '0; m_rdata = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        void'(q[i].pop_front());
        cur_v[i] = 0;
        gap_cnt[i] = 0;
      end
      if (!cur_v[i] && q[i].size() > 0) begin
        if (gap_cnt[i] >= q[i][0].gap) cur_v[i] = 1;
        else gap_cnt[i]++;
      end
      if (cur_v[i]) begin
        bus.req_we[i]   = q[i][0].we;
        bus.req_last[i] = q[i][0].last;
        bus.req_addr[i*AW +: AW]       = q[i][0].addr;
        bus.req_wdata[i*WIDTH +: WIDTH] = q[i][0].data;
      end else begin
        bus.req_we[i]   = 1'($urandom);
        bus.req_last[i] = 1'($urandom);
        bus.req_addr[i*AW +: AW]       = AW'($urandom);
        bus.req_wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
    end
    bus.req_valid = cur_v;
    acc = '0;
  endtask

  task automatic model_step();
    int g;
    bit [NREQ-1:0] exp_rdy;
    bit we;
    bit last;
    bit [AW-1:0] a;
    bit [WIDTH-1:0] wd;
    g = -1;
    if (!rst) begin
      if (m_burst) begin
        if (bus.req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          int i;
          i = (m_lo + k) % NREQ;
          if (g < 0 && bus.req_valid[i]) g = i;
        end
      end
    end
    exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("mem_en", 32'(bus.mem_en), 32'(g >= 0));
    if (g >= 0) begin
      we   = bus.req_we[g];
      last = bus.req_last[g];
      a    = bus.req_addr[g*AW +: AW];
      wd   = bus.req_wdata[g*WIDTH +: WIDTH];
      chk("mem_we", 32'(bus.mem_we), 32'(we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(a));
      if (we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
    end else begin
      we = 0; last = 0; a = '0; wd = '0;
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp));
    if (m_rsp != 0) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
    chk("busy", 32'(busy), 32'(m_burst || m_rsp != 0));

    acc = exp_rdy;
    if (rst) begin
      model_reset();
      return;
    end
    m_rsp = (g >= 0 && !we) ? NREQ'(1 << g) : '0;
    if (g >= 0) begin
      if (we) ref_mem[a] = wd;
      else    m_rdata = ref_mem[a];
      if (!m_burst) begin
        if (last || MB == 1) m_lo = g;
        else begin m_burst = 1; m_owner = g; m_cnt = 1; end
      end else begin
        m_cnt++;
        if (last || m_cnt == MB) begin m_burst = 0; m_lo = m_owner; m_cnt = 0; end
      end
    end
  endtask

  task automatic push(input int r, input int gap, input bit we, input bit last,
                      input int addr, input int data);
    beat_t b;
    b.gap = gap; b.we = we; b.last = last; b.addr = AW'(addr); b.data = WIDTH'(data);
    q[r].push_back(b);
  endtask

  task automatic run(input int maxc, input int rst_at);
    bit done;
    done = 0;
    for (int c = 0; c < maxc && !done; c++) begin
      @(posedge clk); #1;
      drive();
      rst = (c == rst_at);
      @(negedge clk);
      model_step();
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("post_rst_busy", 32'(busy), 32'(0));
        chk("post_rst_rsp", 32'(bus.rsp_valid), 32'(0));
      end
      done = (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0) &&
             (cur_v == 0) && (m_rsp == 0) && !m_burst;
    end
    if (!done) chk("timeout", 32'(0), 32'(1));
  endtask

  initial begin
    cur_v = '0; acc = '0;
    for (int i = 0; i < NREQ; i++) gap_cnt[i] = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_reset();

    // Reset holds ready/mem_en low even with every requester valid.
    rst = 1;
    bus.req_valid = '1; bus.req_we = '0; bus.req_last = '1;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'(0));
      chk("rst_mem_en", 32'(bus.mem_en), 32'(0));
    end
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rsp", 32'(bus.rsp_valid), 32'(0));
    @(posedge clk); #1;
    rst = 0; bus.req_valid = '0;

    // Single-beat write then read of the same word.
    push(0, 0, 1, 1, 5, 16'hBEEF);
    push(0, 0, 0, 1, 5, 0);
    run(50, -1);

    // Known contents for the low addresses used below.
    for (int a = 0; a < 16; a++) push(0, 0, 1, a == 15, a, 16'h1000 + a * 16'h0111);
    run(100, -1);

    // All three requesters with single-beat reads: rotating grants.
    for (int r = 0; r < NREQ; r++) begin
      push(r, 0, 0, 1, r + 1, 0);
      push(r, 0, 0, 1, r + 1, 0);
    end
    run(50, -1);

    // req1 4-beat write burst with req0/req2 waiting.
    for (int b = 0; b < 4; b++) push(1, 0, 1, b == 3, 8 + b, 16'hA000 + b);
    push(0, 1, 0, 1, 9, 0);
    push(2, 1, 0, 1, 10, 0);
    run(50, -1);

    // req0 32 beats, no req_last until the end: forced release at 16.
    for (int b = 0; b < 32; b++) push(0, 0, b[0], b == 31, b % 16, 16'hC000 + b);
    push(1, 5, 0, 1, 3, 0);
    run(200, -1);

    // req2 burst with a 3-cycle bubble while req0 waits.
    push(2, 0, 1, 0, 12, 16'h2222);
    push(2, 3, 0, 0, 12, 0);
    push(2, 0, 0, 1, 11, 0);
    push(0, 1, 0, 1, 4, 0);
    run(50, -1);

    // Reset mid-burst with read responses in flight.
    for (int b = 0; b < 10; b++) push(0, 0, 0, b == 9, b, 0);
    push(1, 3, 0, 1, 1, 0);
    push(2, 3, 0, 1, 2, 0);
    run(100, 5);

    // Randomised traffic.
    for (int r = 0; r < NREQ; r++)
      for (int b = 0; b < 30; b++)
        push(r, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
             1'($urandom), (b == 29) || ($urandom_range(0, 3) == 0),
             $urandom_range(0, 15), $urandom);
    run(2000, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
